// File: rtl/traffic_pkg.sv
// traffic_pkg: shared types and helpers for the two-road intersection controller.
//   phase_t     - 3-bit phase encoding, also exported on the debug 'phase' port
//   lamps_t     - {main r,y,g, side r,y,g} lamp bundle
//   max_of4     - elaboration-time maximum, used to size the phase timer
//   lamp_decode - steady-state lamp pattern for a phase (FLASH yields all-off;
//                 the blinking lamps are overlaid by the top level)
package traffic_pkg;

    typedef enum logic [2:0] {
        CLR_2  = 3'd0,
        MAIN_G = 3'd1,
        MAIN_Y = 3'd2,
        CLR_1  = 3'd3,
        SIDE_G = 3'd4,
        SIDE_Y = 3'd5,
        FLASH  = 3'd6
    } phase_t;

    typedef struct packed {
        logic main_r;
        logic main_y;
        logic main_g;
        logic side_r;
        logic side_y;
        logic side_g;
    } lamps_t;

    function automatic int max_of4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    function automatic lamps_t lamp_decode(input phase_t p);
        lamps_t l;
        l = '0;
        case (p)
            MAIN_G: begin l.main_g = 1'b1; l.side_r = 1'b1; end
            MAIN_Y: begin l.main_y = 1'b1; l.side_r = 1'b1; end
            SIDE_G: begin l.main_r = 1'b1; l.side_g = 1'b1; end
            SIDE_Y: begin l.main_r = 1'b1; l.side_y = 1'b1; end
            FLASH:  l = '0;
            // CLR_1, CLR_2 and any unused code: fail safe to all-red
            default: begin l.main_r = 1'b1; l.side_r = 1'b1; end
        endcase
        return l;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// phase_timer: loadable down-counter that times each controller phase.
//   clk, rst  - clock, synchronous active-high reset (count <= RST_VAL)
//   load      - load load_val this cycle (wins over the decrement)
//   load_val  - value loaded, normally duration-1 of the phase being entered
//   zero      - count is zero; the counter parks there until the next load
module phase_timer #(
    parameter int               CNT_W   = 4,
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= RST_VAL;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/traffic_sequencer.sv
// traffic_sequencer: timed two-road intersection controller.
// Sequences CLR_2 -> MAIN_G -> MAIN_Y -> CLR_1 -> SIDE_G -> SIDE_Y -> CLR_2.
// Main green is held (after its minimum time) until a side request is latched.
// Optional night-flash mode is compiled in with `define TRAFFIC_FLASH_EN.
//   clk, rst          - clock, synchronous active-high reset
//   side_req          - side-road request, level-sampled each cycle
//   flash_mode        - night flash request (TRAFFIC_FLASH_EN builds only)
//   main_red/yellow/green, side_red/yellow/green - lamp drivers (registered state decode)
//   phase             - current phase_t encoding, for debug
// Each phase lasts exactly its duration: the timer loads duration-1 on entry
// and the phase is left in the cycle where the timer reads zero.
module traffic_sequencer
    import traffic_pkg::*;
#(
    parameter int GREEN_MAIN = 20,
    parameter int GREEN_SIDE = 10,
    parameter int YELLOW     = 4,
    parameter int ALL_RED    = 2,
    parameter int FLASH_HALF = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       side_req,
`ifdef TRAFFIC_FLASH_EN
    input  logic       flash_mode,
`endif
    output logic       main_red,
    output logic       main_yellow,
    output logic       main_green,
    output logic       side_red,
    output logic       side_yellow,
    output logic       side_green,
    output logic [2:0] phase
);

    localparam int MAX_DUR = max_of4(GREEN_MAIN, GREEN_SIDE, YELLOW, ALL_RED);
    localparam int CNT_W   = $clog2(MAX_DUR + 1);

    // Zero-length phases would break the "lasts exactly duration cycles" rule.
    if (GREEN_MAIN < 1 || GREEN_SIDE < 1 || YELLOW < 1 || ALL_RED < 1 || FLASH_HALF < 1) begin : g_bad_param
        $error("traffic_sequencer: every duration parameter must be >= 1");
    end

    function automatic logic [CNT_W-1:0] dur_m1(input phase_t p);
        case (p)
            MAIN_G:       return CNT_W'(GREEN_MAIN - 1);
            SIDE_G:       return CNT_W'(GREEN_SIDE - 1);
            MAIN_Y,
            SIDE_Y:       return CNT_W'(YELLOW - 1);
            CLR_1, CLR_2: return CNT_W'(ALL_RED - 1);
            default:      return '0;
        endcase
    endfunction

    phase_t           state_q, state_d;
    logic             req_q;
    logic             req_clr;
    logic             timer_load;
    logic [CNT_W-1:0] timer_load_val;
    logic             timer_zero;
    lamps_t           lamps;

    phase_timer #(
        .CNT_W   (CNT_W),
        .RST_VAL (CNT_W'(ALL_RED - 1))
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (timer_load_val),
        .zero     (timer_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLR_2;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        req_clr = 1'b0;
        case (state_q)
            CLR_2:  if (timer_zero) state_d = MAIN_G;
            MAIN_G: if (timer_zero && req_q) state_d = MAIN_Y;
            MAIN_Y: if (timer_zero) state_d = CLR_1;
            CLR_1: begin
                if (timer_zero) begin
                    state_d = SIDE_G;
                    req_clr = 1'b1;    // this side cycle consumes the request
                end
            end
            SIDE_G: if (timer_zero) state_d = SIDE_Y;
            SIDE_Y: if (timer_zero) state_d = CLR_2;
            // Leaving FLASH (or recovering from an unused code) always clears first.
            default: state_d = CLR_2;
        endcase
`ifdef TRAFFIC_FLASH_EN
        if (flash_mode) begin
            state_d = FLASH;
            req_clr = 1'b0;            // the pending request survives flash
        end
`endif
        // Any phase change reloads the timer with the full new duration.
        timer_load     = (state_d != state_q);
        timer_load_val = dur_m1(state_d);
    end

    // Request latch: clear beats a same-cycle set; frozen while flashing.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_q <= 1'b0;
        end else if (req_clr) begin
            req_q <= 1'b0;
        end else if (side_req && (state_q != FLASH)) begin
            req_q <= 1'b1;
        end
    end

`ifdef TRAFFIC_FLASH_EN
    localparam int FL_W = $clog2(FLASH_HALF + 1);

    logic [FL_W-1:0] blink_cnt_q;
    logic            blink_on_q;

    // Held preloaded outside FLASH so the first flash cycle starts ON.
    always_ff @(posedge clk) begin
        if (rst || (state_q != FLASH)) begin
            blink_cnt_q <= FL_W'(FLASH_HALF - 1);
            blink_on_q  <= 1'b1;
        end else if (blink_cnt_q == '0) begin
            blink_cnt_q <= FL_W'(FLASH_HALF - 1);
            blink_on_q  <= ~blink_on_q;
        end else begin
            blink_cnt_q <= blink_cnt_q - 1'b1;
        end
    end
`endif

    always_comb begin
        lamps = lamp_decode(state_q);
`ifdef TRAFFIC_FLASH_EN
        if (state_q == FLASH) begin
            lamps.main_y = blink_on_q;
            lamps.side_r = blink_on_q;
        end
`endif
    end

    assign main_red    = lamps.main_r;
    assign main_yellow = lamps.main_y;
    assign main_green  = lamps.main_g;
    assign side_red    = lamps.side_r;
    assign side_yellow = lamps.side_y;
    assign side_green  = lamps.side_g;
    assign phase       = state_q;

endmodule

// File: tb/tb_traffic_sequencer.sv
// tb_traffic_sequencer: directed scenarios with short durations
// (GREEN_MAIN=5, GREEN_SIDE=3, YELLOW=2, ALL_RED=1, FLASH_HALF=2).
// One loop of the sequence is 5+2+1+3+2+1 = 14 cycles.
module tb_traffic_sequencer;

    localparam int GM = 5;
    localparam int GS = 3;
    localparam int YL = 2;
    localparam int AR = 1;
    localparam int FH = 2;

    // {main r,y,g, side r,y,g}
    localparam logic [5:0] L_MG = 6'b001_100;
    localparam logic [5:0] L_MY = 6'b010_100;
    localparam logic [5:0] L_RR = 6'b100_100;
    localparam logic [5:0] L_SG = 6'b100_001;
    localparam logic [5:0] L_SY = 6'b100_010;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       side_req = 1'b0;
    logic       flash_mode = 1'b0;
    logic       main_red, main_yellow, main_green;
    logic       side_red, side_yellow, side_green;
    logic [2:0] phase;
    logic [5:0] lamps;

    int checks = 0;
    int errors = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    traffic_sequencer #(
        .GREEN_MAIN (GM),
        .GREEN_SIDE (GS),
        .YELLOW     (YL),
        .ALL_RED    (AR),
        .FLASH_HALF (FH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .side_req    (side_req),
`ifdef TRAFFIC_FLASH_EN
        .flash_mode  (flash_mode),
`endif
        .main_red    (main_red),
        .main_yellow (main_yellow),
        .main_green  (main_green),
        .side_red    (side_red),
        .side_yellow (side_yellow),
        .side_green  (side_green),
        .phase       (phase)
    );

    assign lamps = {main_red, main_yellow, main_green, side_red, side_yellow, side_green};

    // Expected {phase, lamps} at cycle i of a loop, cycle 0 = first MAIN_G cycle.
    function automatic logic [8:0] loop_exp(input int i);
        if (i < 5)  return {3'd1, L_MG};
        if (i < 7)  return {3'd2, L_MY};
        if (i < 8)  return {3'd3, L_RR};
        if (i < 11) return {3'd4, L_SG};
        if (i < 13) return {3'd5, L_SY};
        return {3'd0, L_RR};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        side_req   = 1'b0;
        flash_mode = 1'b0;
        repeat (3) step();
        rst = 1'b0;
    endtask

    // ---------------- safety monitor ----------------
    always @(negedge clk) begin
        if (!rst && phase !== 3'd6) begin
            checks++;
            if (main_red === 1'b0 && side_red === 1'b0) begin
                errors++;
                $display("FAIL safety t=%0t got main_red=0 side_red=0 want at least one red", $time);
            end
        end
    end

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        side_req = 1'b0;
        repeat (3) step();
        checks++;
        if ({phase, lamps} !== {3'd0, L_RR}) begin
            errors++;
            $display("FAIL reset_hold got ph=%0d lamps=%b want ph=0 lamps=%b", phase, lamps, L_RR);
        end
        rst = 1'b0;
        checks++;
        if ({phase, lamps} !== {3'd0, L_RR}) begin
            errors++;
            $display("FAIL reset_release_allred got ph=%0d lamps=%b want ph=0 lamps=%b", phase, lamps, L_RR);
        end
        step();
        for (int i = 0; i < 50; i++) begin
            checks++;
            if ({phase, lamps} !== {3'd1, L_MG}) begin
                errors++;
                $display("FAIL reset_main_hold cyc %0d got ph=%0d lamps=%b want ph=1 lamps=%b", i, phase, lamps, L_MG);
            end
            step();
        end
    endtask

    task automatic test_single_pulse();
        do_reset();
        step();
        for (int i = 0; i < 30; i++) begin
            logic [8:0] exp;
            exp = (i < 14) ? loop_exp(i) : {3'd1, L_MG};
            checks++;
            if ({phase, lamps} !== exp) begin
                errors++;
                $display("FAIL pulse cyc %0d got ph=%0d lamps=%b want ph=%0d lamps=%b",
                         i, phase, lamps, exp[8:6], exp[5:0]);
            end
            side_req = (i == 1);
            step();
        end
        side_req = 1'b0;
    endtask

    task automatic test_request_held();
        do_reset();
        side_req = 1'b1;
        step();
        for (int i = 0; i < 42; i++) begin
            logic [8:0] exp;
            exp = loop_exp(i % 14);
            checks++;
            if ({phase, lamps} !== exp) begin
                errors++;
                $display("FAIL held cyc %0d got ph=%0d lamps=%b want ph=%0d lamps=%b",
                         i, phase, lamps, exp[8:6], exp[5:0]);
            end
            step();
        end
        side_req = 1'b0;
    endtask

    task automatic test_reset_mid_phase();
        do_reset();
        side_req = 1'b1;
        step();
        repeat (9) step();   // cycle 9 of the loop = second SIDE_G cycle
        checks++;
        if ({phase, lamps} !== {3'd4, L_SG}) begin
            errors++;
            $display("FAIL midrst_pre got ph=%0d lamps=%b want ph=4 lamps=%b", phase, lamps, L_SG);
        end
        rst = 1'b1;
        step();
        checks++;
        if ({phase, lamps} !== {3'd0, L_RR}) begin
            errors++;
            $display("FAIL midrst_now got ph=%0d lamps=%b want ph=0 lamps=%b", phase, lamps, L_RR);
        end
        rst = 1'b0;
        side_req = 1'b0;
        step();
        for (int i = 0; i < 20; i++) begin
            checks++;
            if ({phase, lamps} !== {3'd1, L_MG}) begin
                errors++;
                $display("FAIL midrst_main_hold cyc %0d got ph=%0d lamps=%b want ph=1 lamps=%b", i, phase, lamps, L_MG);
            end
            step();
        end
    endtask

`ifdef TRAFFIC_FLASH_EN
    task automatic test_flash();
        logic [5:0] blink;
        blink = 6'b110011;   // bit 5 = first flash cycle
        do_reset();
        side_req = 1'b1;
        step();
        repeat (8) step();   // first SIDE_G cycle
        checks++;
        if ({phase, lamps} !== {3'd4, L_SG}) begin
            errors++;
            $display("FAIL flash_pre got ph=%0d lamps=%b want ph=4 lamps=%b", phase, lamps, L_SG);
        end
        flash_mode = 1'b1;
        side_req = 1'b0;
        step();
        for (int i = 0; i < 6; i++) begin
            logic       b;
            logic [5:0] exp;
            b   = blink[5 - i];
            exp = {1'b0, b, 1'b0, b, 2'b00};
            checks++;
            if ({phase, lamps} !== {3'd6, exp}) begin
                errors++;
                $display("FAIL flash cyc %0d got ph=%0d lamps=%b want ph=6 lamps=%b", i, phase, lamps, exp);
            end
            if (i == 5) flash_mode = 1'b0;
            step();
        end
        checks++;
        if ({phase, lamps} !== {3'd0, L_RR}) begin
            errors++;
            $display("FAIL flash_exit_clr got ph=%0d lamps=%b want ph=0 lamps=%b", phase, lamps, L_RR);
        end
        step();
        checks++;
        if ({phase, lamps} !== {3'd1, L_MG}) begin
            errors++;
            $display("FAIL flash_exit_main got ph=%0d lamps=%b want ph=1 lamps=%b", phase, lamps, L_MG);
        end
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single_pulse();
        test_request_held();
        test_reset_mid_phase();
`ifdef TRAFFIC_FLASH_EN
        test_flash();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
